// File: rtl/beam_sum_engine_pkg.sv
// -----------------------------------------------------------------------------
// beam_sum_engine_pkg
// Shared types and width helpers for the delay-and-sum beamformer core.
//   state_t    : FSM encoding (IDLE / ACCUM / OUT)
//   clog2      : ceil(log2(value)), value >= 1
//   acc_width  : accumulator width IN_W + clog2(N_CH) (holds N_CH full-scale samples)
//   ptr_width  : delay-buffer pointer width for a power-of-two DEPTH
// -----------------------------------------------------------------------------
package beam_sum_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      width++;
    end
    return width;
  endfunction

  function automatic int acc_width(input int in_w, input int n_ch);
    return in_w + clog2(n_ch);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

endpackage

// File: rtl/beam_sum_engine_if.sv
// -----------------------------------------------------------------------------
// beam_sum_engine_if
// Valid/ready beam-sample stream from the beamformer toward the I2S serializer.
//   out_data  : signed beam sample, held stable while out_valid is high
//   out_valid : out_data valid
//   out_ready : downstream accept; transfer on out_valid && out_ready
// Modports: master = beamformer (producer), slave = serializer (consumer).
// OUT_W must match the OUT_W of the connected beam_sum_engine.
// -----------------------------------------------------------------------------
interface beam_sum_engine_if #(
  parameter int OUT_W = 20
);

  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/beam_sum_engine_delay_ram.sv
// -----------------------------------------------------------------------------
// beam_sum_engine_delay_ram
// N_CH x DEPTH x IN_W register file holding the per-channel circular delay
// buffers. All channels share one write pointer and are written as a full row;
// a single asynchronous read port selects one channel and one slot.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears every entry)
//   we        : write the whole row at wr_ptr
//   wr_ptr    : shared write slot
//   wr_row    : channel c at [c*IN_W +: IN_W]
//   rd_ch     : channel to read
//   rd_addr   : slot to read
//   rd_data   : combinational read data
// -----------------------------------------------------------------------------
module beam_sum_engine_delay_ram
  import beam_sum_engine_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int IN_W  = 19,
  parameter int DEPTH = 32,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CH_W  = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [N_CH*IN_W-1:0]   wr_row,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic [PTR_W-1:0]       rd_addr,
  output logic [IN_W-1:0]        rd_data
);

  logic [IN_W-1:0] mem_q [N_CH][DEPTH];

  // NOTE: this storage is deliberately reset: slots never written since reset
  // stand for silent pre-history and must read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          // NOTE: sequential state is always assigned with <= so every
          // register samples pre-edge values, independent of statement order.
          mem_q[c][d] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < N_CH; c++) begin
        mem_q[c][wr_ptr] <= wr_row[c*IN_W +: IN_W];
      end
    end
  end

  assign rd_data = mem_q[rd_ch][rd_addr];

endmodule

// File: rtl/beam_sum_engine.sv
// -----------------------------------------------------------------------------
// beam_sum_engine
// Parametrised delay-and-sum beamformer core. Each in_valid strobe writes all
// N_CH channels into circular delay buffers, then the channels are summed one
// per cycle with a signed linear steering delay, and one beam sample is
// offered on a valid/ready port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : N_CH signed IN_W samples, channel k at [k*IN_W +: IN_W]
//   in_valid   : one-cycle sample strobe
//   steer      : signed steering word, sampled only with an accepted strobe
//   out_if     : beam sample stream (master modport)
//   busy       : high whenever the FSM is not IDLE
//   overrun    : sticky, a strobe arrived while busy; cleared only by rst
// Configuration macro: BEAM_SAT_EN -- when OUT_W < ACC_W, saturate the sum to
// the OUT_W range instead of keeping its low OUT_W bits.
// -----------------------------------------------------------------------------
module beam_sum_engine
  import beam_sum_engine_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int IN_W    = 19,
  parameter int DEPTH   = 32,
  parameter int STEER_W = 5,
  parameter int OUT_W   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*IN_W-1:0]      in_data,
  input  logic                      in_valid,
  input  logic signed [STEER_W-1:0] steer,
  beam_sum_engine_if.master         out_if,
  output logic                      busy,
  output logic                      overrun
);

  localparam int ACC_W     = acc_width(IN_W, N_CH);
  localparam int PTR_W     = ptr_width(DEPTH);
  localparam int CH_W      = clog2(N_CH);
  localparam int K_W       = clog2(N_CH + 1);
  localparam int DLY_SUM_W = ((PTR_W > STEER_W) ? PTR_W : STEER_W) + 1;

  state_t                  state_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic                    neg_q;
  logic [STEER_W-1:0]      mag_q;
  logic [PTR_W-1:0]        delay_q;
  logic [K_W-1:0]          k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  logic [STEER_W-1:0]      steer_mag;
  logic                    ram_we;
  logic [CH_W-1:0]         rd_ch;
  logic [PTR_W-1:0]        rd_addr;
  logic [IN_W-1:0]         rd_data;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic [DLY_SUM_W-1:0]    delay_sum;
  logic [PTR_W-1:0]        delay_d;
  logic signed [OUT_W-1:0] out_conv;

  // |steer| fits STEER_W bits when read as unsigned, including the most
  // negative steering value.
  assign steer_mag = steer[STEER_W-1] ? STEER_W'(-steer) : STEER_W'(steer);

  // Only an idle engine accepts a strobe; strobes while busy leave the
  // buffers and the write pointer untouched.
  assign ram_we = (state_q == ST_IDLE) && in_valid;

  // Negative steering walks the channels from N_CH-1 down to 0, so the delay
  // register always starts at 0 and grows by |steer| per step in both
  // directions. The sum is order-independent.
  assign rd_ch   = neg_q ? (CH_W'(N_CH - 1) - k_q[CH_W-1:0]) : k_q[CH_W-1:0];
  // wr_ptr_q already points past the newest row; modulo DEPTH by width.
  assign rd_addr = wr_ptr_q - PTR_W'(1) - delay_q;

  assign sample_ext = ACC_W'($signed(rd_data));
  assign acc_d      = acc_q + sample_ext;

  // Saturating delay step: the delay grows monotonically, so clamping each
  // step equals clamping the full product |steer|*k.
  assign delay_sum = DLY_SUM_W'(delay_q) + DLY_SUM_W'(mag_q);

  always_comb begin
    // NOTE: default assignment first so every path writes delay_d and no
    // latch is inferred.
    delay_d = delay_sum[PTR_W-1:0];
    if (delay_sum > DLY_SUM_W'(DEPTH - 1)) begin
      delay_d = PTR_W'(DEPTH - 1);
    end
  end

  generate
    if (OUT_W >= ACC_W) begin : g_out_ext
      assign out_conv = OUT_W'(acc_q);
    end else begin : g_out_narrow
`ifdef BEAM_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

      always_comb begin
        out_conv = acc_q[OUT_W-1:0];
        if (acc_q > SAT_MAX) begin
          out_conv = SAT_MAX[OUT_W-1:0];
        end else if (acc_q < SAT_MIN) begin
          out_conv = SAT_MIN[OUT_W-1:0];
        end
      end
`else
      assign out_conv = acc_q[OUT_W-1:0];
`endif
    end
  endgenerate

  beam_sum_engine_delay_ram #(
    .N_CH  (N_CH),
    .IN_W  (IN_W),
    .DEPTH (DEPTH)
  ) u_delay_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_ptr  (wr_ptr_q),
    .wr_row  (in_data),
    .rd_ch   (rd_ch),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // FSM with registered outputs. ACCUM runs N_CH summing steps (k = 0..N_CH-1)
  // plus one step at k == N_CH that registers the width-converted sum, which
  // keeps the clamp logic off the accumulator adder path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      delay_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (in_valid && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            neg_q    <= steer[STEER_W-1];
            mag_q    <= steer_mag;
            delay_q  <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (k_q == K_W'(N_CH)) begin
            out_data_q  <= out_conv;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            acc_q   <= acc_d;
            delay_q <= delay_d;
            k_q     <= k_q + K_W'(1);
          end
        end

        ST_OUT: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_beam_sum_engine.sv
// -----------------------------------------------------------------------------
// tb_beam_sum_engine
// Self-checking bench for beam_sum_engine (N_CH=8, IN_W=19, DEPTH=32,
// STEER_W=5, OUT_W=20). A reference model keeps every accepted frame in a
// queue and forms each beam sample directly from the steering rule
// delay_k = |steer| * (k or N_CH-1-k), clamped to DEPTH-1.
// -----------------------------------------------------------------------------
module tb_beam_sum_engine;

  localparam int N_CH    = 8;
  localparam int IN_W    = 19;
  localparam int DEPTH   = 32;
  localparam int STEER_W = 5;
  localparam int OUT_W   = 20;
  localparam int LAT     = N_CH + 1;

  typedef int row_t [N_CH];

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [N_CH*IN_W-1:0]      in_data = '0;
  logic                      in_valid = 1'b0;
  logic signed [STEER_W-1:0] steer = '0;
  logic                      out_ready = 1'b1;
  logic                      busy;
  logic                      overrun;
  logic                      out_valid;
  logic [OUT_W-1:0]          out_data;

  int checks = 0;
  int errors = 0;

  row_t hist [$];

  beam_sum_engine_if #(.OUT_W(OUT_W)) out_if ();

  assign out_if.out_ready = out_ready;
  assign out_valid        = out_if.out_valid;
  assign out_data         = out_if.out_data;

  beam_sum_engine #(
    .N_CH    (N_CH),
    .IN_W    (IN_W),
    .DEPTH   (DEPTH),
    .STEER_W (STEER_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .steer    (steer),
    .out_if   (out_if),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic row_t const_row(input int v);
    row_t r;
    foreach (r[i]) r[i] = v;
    return r;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    foreach (r[i]) r[i] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    return r;
  endfunction

  // Beam sample for the newest frame in hist, from the steering rule.
  function automatic logic [OUT_W-1:0] model_out(input int s);
    longint sum;
    int     mag;
    int     f;
    int     d;
    sum = 0;
    mag = (s < 0) ? -s : s;
    f   = hist.size() - 1;
    for (int ch = 0; ch < N_CH; ch++) begin
      d = (s >= 0) ? mag * ch : mag * (N_CH - 1 - ch);
      if (d > DEPTH - 1) d = DEPTH - 1;
      if (f - d >= 0) sum += longint'(hist[f - d][ch]);
    end
`ifdef BEAM_SAT_EN
    if (sum > longint'((1 << (OUT_W - 1)) - 1)) sum = longint'((1 << (OUT_W - 1)) - 1);
    if (sum < -longint'(1 << (OUT_W - 1)))      sum = -longint'(1 << (OUT_W - 1));
`endif
    return sum[OUT_W-1:0];
  endfunction

  task automatic put_row(input row_t r);
    for (int k = 0; k < N_CH; k++) in_data[k*IN_W +: IN_W] = IN_W'(r[k]);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  // One strobe, then latency, data, optional stall hold and release checks.
  task automatic run_frame(input string tag, input row_t row, input int s,
                           input int stall, output logic [OUT_W-1:0] got);
    logic [OUT_W-1:0] exp;
    int n;
    @(negedge clk);
    put_row(row);
    steer     = STEER_W'(s);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    steer    = STEER_W'($urandom);
    put_row(rnd_row());
    hist.push_back(row);
    exp = model_out(s);
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    got = out_data;
    check({tag, "_data"}, out_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {out_valid, out_data}, {1'b1, got});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done"}, {out_valid, busy}, 2'b00);
  endtask

  initial begin
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] exp;
    row_t r;
    int n;

    reset_dut();
    check("rst_out", {out_valid, busy, overrun}, 3'b000);
    check("rst_data", out_data, 0);

    // Broadside sum
    run_frame("sum", const_row(100), 0, 0, got);
    check("sum_800", got, 800);

    // Positive steering: impulse frame walks across the channels
    reset_dut();
    for (int f = 0; f < 10; f++) begin
      run_frame("step", const_row((f == 0) ? 1000 : 0), 1, 0, got);
      check("step_val", got, (f < 8) ? 1000 : 0);
    end

    // Negative steering: channel 7 has zero delay
    reset_dut();
    r = const_row(0);
    r[7] = 1000;
    run_frame("neg", r, -1, 0, got);
    check("neg_1000", got, 1000);

    // Delay clamp at DEPTH-1, also wraps the write pointer
    reset_dut();
    for (int f = 0; f < 32; f++) begin
      r = const_row(0);
      if (f == 0) r[3] = 1000;
      run_frame("clamp", r, 15, 0, got);
      check("clamp_val", got, (f == 31) ? 1000 : 0);
    end

    // Most negative steer and backpressure hold
    run_frame("minsteer", rnd_row(), -16, 0, got);
    run_frame("stall", rnd_row(), 3, 5, got);

    // Overrun: strobes in ACCUM, in OUT and in the handshake cycle are dropped
    reset_dut();
    run_frame("pre", const_row(7), 1, 0, got);
    r = rnd_row();
    @(negedge clk);
    put_row(r);
    steer     = 5'sd1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hist.push_back(r);
    exp = model_out(1);
    repeat (2) @(posedge clk);
    #1;
    put_row(rnd_row());
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ovr_accum", overrun, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ovr_data", out_data, exp);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_out_hold", {out_valid, out_data}, {1'b1, exp});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ovr_hs", {out_valid, busy}, 2'b00);
    check("ovr_sticky", overrun, 1);
    run_frame("post", rnd_row(), 1, 0, got);

    // Reset three cycles into ACCUM clears state, sticky flag and buffers
    @(negedge clk);
    put_row(rnd_row());
    steer    = 5'sd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    check("rst_mid", {out_valid, busy, overrun}, 3'b000);
    run_frame("after_rst", const_row(5), 2, 0, got);
    check("after_rst_5", got, 5);

    // Full-scale sum exceeds the output range
    reset_dut();
    run_frame("big", const_row(262143), 0, 0, got);
`ifdef BEAM_SAT_EN
    check("big_sat", got, 524287);
`else
    check("big_wrap", got, 20'hFFFF8);
`endif

    // Randomized frames against the model
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      run_frame("rnd", rnd_row(), int'($urandom_range(0, 31)) - 16,
                int'($urandom_range(0, 2)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
